// File: rtl/writeback.sv
// ---------------------------------------------------------------------------
// writeback
//
// Write-back stage and architectural register file of the Y86 processor.
// One executed instruction can be presented per cycle. The block works out the
// E and M destination registers and commits the results into fifteen 64-bit
// registers. It also tracks processor status and counts retired instructions.
//
// Optional feature: define WB_BYPASS_EN to forward the value being written
// this cycle straight onto reg_mem_N. Decode then sees the result in the
// same cycle it is accepted.
//
// Parameters
//   SP_INIT        reset value of register 4 (%rsp)
//   CNT_W          width of retired_count
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   instr_valid    an executed instruction is presented this cycle
//   icode          instruction code
//   rA, rB         register specifiers (15 = none)
//   cnd            condition result from execute (cmovxx)
//   valE, valM     ALU result, memory read result
//   dmem_error     data-memory fault for the presented instruction
//   reg_mem_0..14  architectural register values
//   stat           1=AOK, 2=HLT, 3=ADR, 4=INS
//   halted         high in any non-AOK state
//   retired_count  committed-instruction count, saturating
// ---------------------------------------------------------------------------
module writeback #(
  parameter logic [63:0] SP_INIT = 64'h0,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic             dmem_error,
  output logic [63:0]      reg_mem_0,
  output logic [63:0]      reg_mem_1,
  output logic [63:0]      reg_mem_2,
  output logic [63:0]      reg_mem_3,
  output logic [63:0]      reg_mem_4,
  output logic [63:0]      reg_mem_5,
  output logic [63:0]      reg_mem_6,
  output logic [63:0]      reg_mem_7,
  output logic [63:0]      reg_mem_8,
  output logic [63:0]      reg_mem_9,
  output logic [63:0]      reg_mem_10,
  output logic [63:0]      reg_mem_11,
  output logic [63:0]      reg_mem_12,
  output logic [63:0]      reg_mem_13,
  output logic [63:0]      reg_mem_14,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ADR  = 2'd2,
    ST_INS  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       NO_REG  = 4'hF;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      regs_q [15];
  logic [63:0]      regs_d [15];
  logic [63:0]      regsView [15];

  logic       accept;
  logic       badIcode;
  logic       commit;
  logic [3:0] dstE;
  logic [3:0] dstM;

  // Destination selection. cmovxx only writes when the condition held.
  // The stack-touching instructions (call/ret/push/pop) always update %rsp
  // through the E port.
  always_comb begin
    dstE = NO_REG;
    case (icode)
      4'h2:                   if (cnd) dstE = rB;
      4'h3, 4'h6:             dstE = rB;
      4'h8, 4'h9, 4'hA, 4'hB: dstE = 4'h4;
      default:                dstE = NO_REG;
    endcase
    dstM = ((icode == 4'h5) || (icode == 4'hB)) ? rA : NO_REG;
  end

  // An instruction is only taken while running. A faulting or unknown
  // instruction is accepted so that the status can change, but it never
  // commits register writes or counts as retired.
  always_comb begin
    accept   = instr_valid && (state_q == ST_RUN);
    badIcode = (icode > 4'hB);
    commit   = accept && !dmem_error && !badIcode;
  end

  // Next register-file contents. The M write is tested first so that popq
  // %rsp keeps the popped value rather than the incremented stack pointer.
  // A destination of 15 never matches an index below 15, so "no register"
  // falls out naturally.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      regs_d[i] = regs_q[i];
      if (commit) begin
        if (dstM == 4'(i)) begin
          regs_d[i] = valM;
        end else if (dstE == 4'(i)) begin
          regs_d[i] = valE;
        end
      end
    end
  end

  // Register file storage. Register 4 comes out of reset at SP_INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == 4) ? SP_INIT : 64'h0;
      end
    end else begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Retired-instruction counter. It holds at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (commit && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Status FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Status FSM next state. A data fault outranks an invalid icode. All
  // non-running states are sticky until reset.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (dmem_error) begin
        state_d = ST_ADR;
      end else if (badIcode) begin
        state_d = ST_INS;
      end else if (icode == 4'h0) begin
        state_d = ST_HALT;
      end
    end
  end

  // Status FSM outputs.
  always_comb begin
    stat   = 3'd1;
    halted = 1'b0;
    case (state_q)
      ST_RUN:  begin stat = 3'd1; halted = 1'b0; end
      ST_HALT: begin stat = 3'd2; halted = 1'b1; end
      ST_ADR:  begin stat = 3'd3; halted = 1'b1; end
      ST_INS:  begin stat = 3'd4; halted = 1'b1; end
      default: begin stat = 3'd1; halted = 1'b0; end
    endcase
  end

  // Register values seen by decode. With bypass, regs_d already holds the
  // value being committed this cycle, and it is gated by the acceptance
  // conditions. Reset masks it so that nothing leaks through while rst is
  // held.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
`ifdef WB_BYPASS_EN
      regsView[i] = rst ? regs_q[i] : regs_d[i];
`else
      regsView[i] = regs_q[i];
`endif
    end
  end

  assign reg_mem_0     = regsView[0];
  assign reg_mem_1     = regsView[1];
  assign reg_mem_2     = regsView[2];
  assign reg_mem_3     = regsView[3];
  assign reg_mem_4     = regsView[4];
  assign reg_mem_5     = regsView[5];
  assign reg_mem_6     = regsView[6];
  assign reg_mem_7     = regsView[7];
  assign reg_mem_8     = regsView[8];
  assign reg_mem_9     = regsView[9];
  assign reg_mem_10    = regsView[10];
  assign reg_mem_11    = regsView[11];
  assign reg_mem_12    = regsView[12];
  assign reg_mem_13    = regsView[13];
  assign reg_mem_14    = regsView[14];
  assign retired_count = count_q;

endmodule

// File: tb/tb_writeback.sv
// ---------------------------------------------------------------------------
// tb_writeback
//
// Directed testbench for writeback. A behavioural model applies the Y86
// write-back rules to an array of fifteen registers, a status code and a
// counter. A compare process checks every DUT output against the model on
// each falling edge. Hand-computed literals after key instructions pin the
// model itself. The counter is built narrow so that saturation can be
// reached.
// ---------------------------------------------------------------------------
module tb_writeback;

  localparam logic [63:0] SP_INIT = 64'h100;
  localparam int          CNT_W   = 3;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             instrValid = 1'b0;
  logic [3:0]       icode = 4'h1;
  logic [3:0]       rA = 4'hF;
  logic [3:0]       rB = 4'hF;
  logic             cnd = 1'b0;
  logic [63:0]      valE = 64'h0;
  logic [63:0]      valM = 64'h0;
  logic             dmemError = 1'b0;
  logic [63:0]      regMem [15];
  logic [2:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] retiredCount;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  // Model state: committed registers, status code and retired count.
  logic [63:0] mRegs [15];
  int          mStat;
  int          mCount;
  // Model state after the presented instruction, if it were taken.
  logic [63:0] nRegs [15];
  int          nStat;
  int          nCount;

  writeback #(.SP_INIT(SP_INIT), .CNT_W(CNT_W)) dut (
    .clk(clock), .rst(reset), .instr_valid(instrValid), .icode(icode),
    .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
    .dmem_error(dmemError),
    .reg_mem_0(regMem[0]),   .reg_mem_1(regMem[1]),   .reg_mem_2(regMem[2]),
    .reg_mem_3(regMem[3]),   .reg_mem_4(regMem[4]),   .reg_mem_5(regMem[5]),
    .reg_mem_6(regMem[6]),   .reg_mem_7(regMem[7]),   .reg_mem_8(regMem[8]),
    .reg_mem_9(regMem[9]),   .reg_mem_10(regMem[10]), .reg_mem_11(regMem[11]),
    .reg_mem_12(regMem[12]), .reg_mem_13(regMem[13]), .reg_mem_14(regMem[14]),
    .stat(stat), .halted(halted), .retired_count(retiredCount)
  );

  // 10-time-unit clock.
  always #5 clock = ~clock;

  // Every comparison goes through here so that the counts stay consistent.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model state immediately after reset.
  function automatic void modelReset();
    for (int i = 0; i < 15; i++) mRegs[i] = (i == 4) ? SP_INIT : 64'h0;
    mStat  = 1;
    mCount = 0;
  endfunction

  // Apply the write-back rules to the currently presented instruction.
  function automatic void computeNext();
    int e;
    int m;
    for (int i = 0; i < 15; i++) nRegs[i] = mRegs[i];
    nStat  = mStat;
    nCount = mCount;
    if (!(instrValid && mStat == 1)) return;
    if (dmemError) begin nStat = 3; return; end
    if (int'(icode) > 11) begin nStat = 4; return; end
    e = 15;
    m = 15;
    if ((icode == 2 && cnd) || icode == 3 || icode == 6) e = int'(rB);
    if (icode >= 8 && icode <= 11) e = 4;
    if (icode == 5 || icode == 11) m = int'(rA);
    if (e != 15) nRegs[e] = valE;
    if (m != 15) nRegs[m] = valM;
    if (icode == 0) nStat = 2;
    if (mCount < CNT_MAX) nCount = mCount + 1;
  endfunction

  // Cycle-by-cycle comparison against the model. With bypass enabled,
  // decode sees the model's post-instruction register values.
  always @(negedge clock) begin
    if (checkEn && !reset) begin
`ifdef WB_BYPASS_EN
      computeNext();
      for (int i = 0; i < 15; i++)
        checkOutput($sformatf("reg_mem_%0d", i), regMem[i], nRegs[i]);
`else
      for (int i = 0; i < 15; i++)
        checkOutput($sformatf("reg_mem_%0d", i), regMem[i], mRegs[i]);
`endif
      checkOutput("stat", 64'(stat), 64'(mStat));
      checkOutput("halted", 64'(halted), 64'(mStat != 1));
      checkOutput("retired_count", 64'(retiredCount), 64'(mCount));
    end
  end

  // Present one instruction for one rising edge, then update the model.
  task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] a,
                               input logic [3:0] b, input logic c,
                               input logic [63:0] e, input logic [63:0] m,
                               input logic err);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
    dmemError = err; instrValid = 1'b1;
    @(posedge clock);
    if (!reset) begin
      computeNext();
      for (int i = 0; i < 15; i++) mRegs[i] = nRegs[i];
      mStat  = nStat;
      mCount = nCount;
    end
    #1;
    instrValid = 1'b0;
    dmemError  = 1'b0;
  endtask

  // Assert reset away from any clock edge, hold it across one rising edge,
  // and release it between edges.
  task automatic doReset();
    @(negedge clock);
    #1;
    instrValid = 1'b0;
    reset = 1'b1;
    modelReset();
    #12;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    modelReset();
    #12;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkEn = 1'b1;

    $display("[TB] reset state");
    checkOutput("lit reset reg_mem_4", regMem[4], 64'h100);
    checkOutput("lit reset reg_mem_2", regMem[2], 64'h0);
    checkOutput("lit reset stat", 64'(stat), 64'd1);
    checkOutput("lit reset count", 64'(retiredCount), 64'd0);

    $display("[TB] irmovq / OPq / popq %%rsp / cmovxx");
    applyStimulus(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 1'b0);
    checkOutput("lit irmovq reg_mem_2", regMem[2], 64'h1234);
    applyStimulus(4'h6, 4'h1, 4'h2, 1'b0, 64'h55, 64'h0, 1'b0);
    checkOutput("lit OPq reg_mem_2", regMem[2], 64'h55);
    checkOutput("lit OPq count", 64'(retiredCount), 64'd2);
    applyStimulus(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hBEEF, 1'b0);
    checkOutput("lit popq reg_mem_4", regMem[4], 64'hBEEF);
    applyStimulus(4'h2, 4'h1, 4'h3, 1'b0, 64'h7, 64'h0, 1'b0);
    checkOutput("lit cmov cnd0 reg_mem_3", regMem[3], 64'h0);
    applyStimulus(4'h2, 4'h1, 4'h3, 1'b1, 64'h7, 64'h0, 1'b0);
    checkOutput("lit cmov cnd1 reg_mem_3", regMem[3], 64'h7);

    $display("[TB] halt and sticky status");
    applyStimulus(4'h0, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0);
    checkOutput("lit halt stat", 64'(stat), 64'd2);
    checkOutput("lit halt halted", 64'(halted), 64'd1);
    applyStimulus(4'h3, 4'hF, 4'h2, 1'b0, 64'h999, 64'h0, 1'b0);
    checkOutput("lit halted irmovq reg_mem_2", regMem[2], 64'h55);
    checkOutput("lit halted count", 64'(retiredCount), 64'd6);
    doReset();
    checkOutput("lit after reset stat", 64'(stat), 64'd1);

    $display("[TB] invalid icode");
    applyStimulus(4'hC, 4'h1, 4'h1, 1'b1, 64'h11, 64'h22, 1'b0);
    checkOutput("lit ins stat", 64'(stat), 64'd4);
    checkOutput("lit ins reg_mem_1", regMem[1], 64'h0);
    checkOutput("lit ins count", 64'(retiredCount), 64'd0);

    $display("[TB] data memory fault");
    doReset();
    applyStimulus(4'h3, 4'hF, 4'h5, 1'b0, 64'h77, 64'h0, 1'b0);
    applyStimulus(4'h5, 4'h5, 4'h1, 1'b0, 64'h40, 64'hDEAD, 1'b1);
    checkOutput("lit adr stat", 64'(stat), 64'd3);
    checkOutput("lit adr reg_mem_5", regMem[5], 64'h77);
    checkOutput("lit adr count", 64'(retiredCount), 64'd1);
    // A fault together with an invalid icode still reports ADR.
    doReset();
    applyStimulus(4'hE, 4'h1, 4'h1, 1'b0, 64'h0, 64'h0, 1'b1);
    checkOutput("lit adr+ins stat", 64'(stat), 64'd3);

    $display("[TB] mrmovq / pushq / jXX / counter saturation");
    doReset();
    applyStimulus(4'h5, 4'h6, 4'h1, 1'b0, 64'h40, 64'hAA, 1'b0);
    applyStimulus(4'hA, 4'h1, 4'hF, 1'b0, 64'hF8, 64'h0, 1'b0);
    applyStimulus(4'h7, 4'hF, 4'hF, 1'b1, 64'h1, 64'h2, 1'b0);
    applyStimulus(4'h5, 4'hF, 4'h1, 1'b0, 64'h40, 64'h33, 1'b0);
    for (int k = 1; k <= 5; k++)
      applyStimulus(4'h3, 4'hF, 4'h1, 1'b0, 64'(k * 16), 64'h0, 1'b0);
    checkOutput("lit mrmovq reg_mem_6", regMem[6], 64'hAA);
    checkOutput("lit pushq reg_mem_4", regMem[4], 64'hF8);
    checkOutput("lit last irmovq reg_mem_1", regMem[1], 64'h50);
    checkOutput("lit saturated count", 64'(retiredCount), 64'd7);

    $display("[TB] asynchronous reset mid-stream");
    icode = 4'h3; rA = 4'hF; rB = 4'h7; cnd = 1'b0;
    valE = 64'hCAFE; valM = 64'h0; instrValid = 1'b1;
    #3;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("lit async reg_mem_1", regMem[1], 64'h0);
    checkOutput("lit async reg_mem_4", regMem[4], 64'h100);
    checkOutput("lit async count", 64'(retiredCount), 64'd0);
    checkOutput("lit async stat", 64'(stat), 64'd1);
    @(posedge clock);
    #1;
    checkOutput("lit held reset reg_mem_7", regMem[7], 64'h0);
    instrValid = 1'b0;
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    applyStimulus(4'h3, 4'hF, 4'h7, 1'b0, 64'hCAFE, 64'h0, 1'b0);
    checkOutput("lit post reset reg_mem_7", regMem[7], 64'hCAFE);

    repeat (3) @(posedge clock);
    #1;
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
